// File: rtl/sa_tile_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sa_tile_engine                                               |
// | Description : Output-stationary systolic array computing one SA_R x SA_C   |
// |               tile of X*W in signed fixed point. X columns enter from the  |
// |               left and move right, W rows enter from the top and move      |
// |               down, and each PE keeps a wide accumulator.                  |
// | Option      : define SA_SAT_EN so results saturate to D_W bits instead of  |
// |               wrapping.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sa_tile_engine #(
  parameter int D_W   = 16,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int FRAC  = 13,
  parameter int K_MAX = 64
) (
  input  logic                           I_CLK,
  input  logic                           I_SYNC_RST,
  input  logic                           I_START,
  input  logic [$clog2(K_MAX+1)-1:0]     I_K_LEN,
  input  logic                           I_VLD,
  output logic                           O_RDY,
  input  logic [SA_R*D_W-1:0]            I_X_COL,
  input  logic [SA_C*D_W-1:0]            I_W_ROW,
  output logic                           O_PE_SHIFT,
  output logic                           O_BUSY,
  output logic                           O_OUT_VLD,
  input  logic                           I_OUT_RDY,
  output logic [SA_R*SA_C*D_W-1:0]       O_OUT
);

  localparam int KW     = $clog2(K_MAX + 1);
  localparam int ACC_W  = 2 * D_W + $clog2(K_MAX);
  // A beat takes SA_R+SA_C-1 cycles to reach the far corner PE, so every
  // skew chain is that long and DRAIN lasts that many cycles.
  localparam int SKEW_L = SA_R + SA_C - 1;
  localparam int DRW    = $clog2(SKEW_L + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    beat_q, beat_d;
  logic [KW-1:0]    klen_q, klen_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             w_clr;
  logic             w_ld_out;
  logic             w_accept;

  // Per-row X chain and per-column W chain; PE(r,c) taps element r+c of both,
  // which yields the skew of one cycle per row plus one per column.
  logic signed [D_W-1:0]    xc_q  [SA_R][SKEW_L];
  logic signed [D_W-1:0]    wc_q  [SA_C][SKEW_L];
  logic signed [ACC_W-1:0]  acc_q [SA_R][SA_C];
  logic signed [ACC_W-1:0]  acc_d [SA_R][SA_C];
  logic signed [2*D_W-1:0]  w_prod [SA_R][SA_C];
  logic [SA_R*SA_C*D_W-1:0] out_q, out_d;

  assign O_RDY      = (state_q == ST_LOAD);
  assign w_accept   = I_VLD & O_RDY;
  assign O_PE_SHIFT = w_accept;
  assign O_BUSY     = (state_q != ST_IDLE);
  assign O_OUT_VLD  = (state_q == ST_DONE);
  assign O_OUT      = out_q;

  // Control registers: state, accepted-beat count, latched K, drain count.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      klen_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      klen_q  <= klen_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; also decides when to clear the array and load O_OUT.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    klen_d   = klen_q;
    drain_d  = drain_q;
    w_clr    = 1'b0;
    w_ld_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          w_clr   = 1'b1;
          beat_d  = '0;
          drain_d = '0;
          klen_d  = (I_K_LEN > KW'(K_MAX)) ? KW'(K_MAX) : I_K_LEN;
          state_d = (klen_d == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          beat_d = beat_q + KW'(1);
          if (beat_d == klen_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DRW'(1);
        if (drain_q == DRW'(SKEW_L - 1)) begin
          state_d  = ST_DONE;
          w_ld_out = 1'b1;
        end
      end
      ST_DONE: begin
        if (I_OUT_RDY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skew chains and accumulators; a non-accepted cycle injects zeros so it
  // contributes nothing to any accumulator.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST || w_clr) begin
      for (int r = 0; r < SA_R; r++) begin
        for (int k = 0; k < SKEW_L; k++) begin
          xc_q[r][k] <= '0;
        end
      end
      for (int c = 0; c < SA_C; c++) begin
        for (int k = 0; k < SKEW_L; k++) begin
          wc_q[c][k] <= '0;
        end
      end
      for (int r = 0; r < SA_R; r++) begin
        for (int c = 0; c < SA_C; c++) begin
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < SA_R; r++) begin
        xc_q[r][0] <= w_accept ? I_X_COL[r*D_W +: D_W] : '0;
        for (int k = 1; k < SKEW_L; k++) begin
          xc_q[r][k] <= xc_q[r][k-1];
        end
      end
      for (int c = 0; c < SA_C; c++) begin
        wc_q[c][0] <= w_accept ? I_W_ROW[c*D_W +: D_W] : '0;
        for (int k = 1; k < SKEW_L; k++) begin
          wc_q[c][k] <= wc_q[c][k-1];
        end
      end
      for (int r = 0; r < SA_R; r++) begin
        for (int c = 0; c < SA_C; c++) begin
          acc_q[r][c] <= acc_d[r][c];
        end
      end
    end
  end

  // PE datapath: full-width product, wide accumulate, then shift and narrow.
  // O_OUT samples the next accumulator value so the corner PE's final
  // product, added on the same edge, is included.
  for (genvar r = 0; r < SA_R; r++) begin : g_row
    for (genvar c = 0; c < SA_C; c++) begin : g_col
      assign w_prod[r][c] = xc_q[r][r+c] * wc_q[c][r+c];
      assign acc_d[r][c]  = acc_q[r][c] + ACC_W'(w_prod[r][c]);
`ifdef SA_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}});
      localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}});
      logic signed [ACC_W-1:0] w_shr;
      assign w_shr = acc_d[r][c] >>> FRAC;
      assign out_d[(r*SA_C+c)*D_W +: D_W] =
        (w_shr > SAT_MAX) ? SAT_MAX[D_W-1:0] :
        (w_shr < SAT_MIN) ? SAT_MIN[D_W-1:0] : w_shr[D_W-1:0];
`else
      assign out_d[(r*SA_C+c)*D_W +: D_W] = D_W'(acc_d[r][c] >>> FRAC);
`endif
    end
  end

  // Result register: updated only on DRAIN->DONE, held otherwise.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      out_q <= '0;
    end else if (w_ld_out) begin
      out_q <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_tile_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sa_tile_engine                                            |
// | Description : Self-checking bench for sa_tile_engine (4x4, Q2.13) against  |
// |               a sum-of-products reference model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sa_tile_engine;

  localparam int D_W   = 16;
  localparam int SA_R  = 4;
  localparam int SA_C  = 4;
  localparam int FRAC  = 13;
  localparam int K_MAX = 64;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int OW    = SA_R * SA_C * D_W;

  logic           clk = 1'b0;
  logic           I_SYNC_RST;
  logic           I_START;
  logic [KW-1:0]  I_K_LEN;
  logic           I_VLD;
  logic           O_RDY;
  logic [SA_R*D_W-1:0] I_X_COL;
  logic [SA_C*D_W-1:0] I_W_ROW;
  logic           O_PE_SHIFT;
  logic           O_BUSY;
  logic           O_OUT_VLD;
  logic           I_OUT_RDY;
  logic [OW-1:0]  O_OUT;

  always #5 clk = ~clk;

  sa_tile_engine #(
    .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .FRAC(FRAC), .K_MAX(K_MAX)
  ) dut (
    .I_CLK(clk), .I_SYNC_RST(I_SYNC_RST), .I_START(I_START), .I_K_LEN(I_K_LEN),
    .I_VLD(I_VLD), .O_RDY(O_RDY), .I_X_COL(I_X_COL), .I_W_ROW(I_W_ROW),
    .O_PE_SHIFT(O_PE_SHIFT), .O_BUSY(O_BUSY), .O_OUT_VLD(O_OUT_VLD),
    .I_OUT_RDY(I_OUT_RDY), .O_OUT(O_OUT)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Operands of the accepted beats of the current tile.
  logic [D_W-1:0] bx [K_MAX][SA_R];
  logic [D_W-1:0] bw [K_MAX][SA_C];
  int             nbeats = 0;

  task automatic chkv(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference: C[i][j] = floor(sum_k x_k[i]*w_k[j] / 2^FRAC), then narrowed.
  function automatic logic [OW-1:0] model_tile();
    logic [OW-1:0] v;
    longint        s;
    v = '0;
    for (int r = 0; r < SA_R; r++) begin
      for (int c = 0; c < SA_C; c++) begin
        s = 0;
        for (int b = 0; b < nbeats; b++) begin
          s += longint'($signed(bx[b][r])) * longint'($signed(bw[b][c]));
        end
        s = s >>> FRAC;
`ifdef SA_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        v[(r*SA_C+c)*D_W +: D_W] = s[D_W-1:0];
      end
    end
    return v;
  endfunction

  // Runs one tile: start, beats (with optional random stalls, a forced gap
  // after beat 2 and spurious starts in stalled cycles), latency and result
  // check, optional back-pressure hold, then consume.
  task automatic run_tile(input int klen, input int stall_pct, input int gap2,
                          input bit fixed, input logic [D_W-1:0] xc,
                          input logic [D_W-1:0] wc, input bit poke, input int hold);
    int            eff, b, g, n, gaps;
    bit            st;
    logic [OW-1:0] exp;
    eff = (klen > K_MAX) ? K_MAX : klen;
    @(negedge clk);
    I_START = 1'b1;
    I_K_LEN = KW'(klen);
    @(negedge clk);
    I_START = 1'b0;
    b = 0; g = 0; gaps = 0;
    while (b < eff && g < 4000) begin
      st = ($urandom_range(99) < stall_pct);
      if (b == 2 && gaps < gap2) begin
        st = 1'b1;
        gaps++;
      end
      I_VLD = !st;
      for (int r = 0; r < SA_R; r++) I_X_COL[r*D_W +: D_W] = fixed ? xc : D_W'($urandom);
      for (int c = 0; c < SA_C; c++) I_W_ROW[c*D_W +: D_W] = fixed ? wc : D_W'($urandom);
      I_START = poke && st;
      I_K_LEN = KW'($urandom);
      #1;
      chk1("rdy_in_load", O_RDY, 1'b1);
      chk1("pe_shift", O_PE_SHIFT, I_VLD);
      if (I_VLD) begin
        for (int r = 0; r < SA_R; r++) bx[b][r] = I_X_COL[r*D_W +: D_W];
        for (int c = 0; c < SA_C; c++) bw[b][c] = I_W_ROW[c*D_W +: D_W];
        b++;
      end
      @(negedge clk);
      g++;
    end
    I_VLD   = 1'b0;
    I_START = 1'b0;
    nbeats  = eff;
    n = 1;
    while (!O_OUT_VLD && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("out_vld_timeout", O_OUT_VLD, 1'b1);
    chki("out_latency", n, SA_R + SA_C);
    exp = model_tile();
    chkv("tile_result", O_OUT, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chkv("hold_out", O_OUT, exp);
      chk1("hold_vld", O_OUT_VLD, 1'b1);
    end
    I_OUT_RDY = 1'b1;
    @(negedge clk);
    I_OUT_RDY = 1'b0;
    chk1("busy_after_consume", O_BUSY, 1'b0);
    chk1("vld_after_consume", O_OUT_VLD, 1'b0);
    chkv("out_retained_idle", O_OUT, exp);
  endtask

  initial begin
    I_SYNC_RST = 1'b1;
    I_START    = 1'b0;
    I_K_LEN    = '0;
    I_VLD      = 1'b0;
    I_X_COL    = '0;
    I_W_ROW    = '0;
    I_OUT_RDY  = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_rdy", O_RDY, 1'b0);
    chk1("rst_pe_shift", O_PE_SHIFT, 1'b0);
    chk1("rst_busy", O_BUSY, 1'b0);
    chk1("rst_out_vld", O_OUT_VLD, 1'b0);
    chkv("rst_out", O_OUT, '0);
    I_SYNC_RST = 1'b0;

    // 1.0 * 0.5 over three beats
    run_tile(3, 0, 0, 1'b1, 16'h2000, 16'h1000, 1'b0, 0);
    chkv("k3_const", O_OUT, {16{16'h3000}});

    // -1.0 * 1.0 over two beats
    run_tile(2, 0, 0, 1'b1, 16'hE000, 16'h2000, 1'b0, 0);
    chkv("k2_neg_const", O_OUT, {16{16'hC000}});

    // 16.0 overflows the output format
    run_tile(16, 0, 0, 1'b1, 16'h2000, 16'h2000, 1'b0, 0);
`ifdef SA_SAT_EN
    chkv("k16_overflow", O_OUT, {16{16'h7FFF}});
`else
    chkv("k16_overflow", O_OUT, {16{16'h0000}});
`endif

    // Three-cycle gap after beat 2, spurious starts during the gap
    run_tile(4, 0, 3, 1'b0, '0, '0, 1'b1, 0);

    // Consumer stalls 20 cycles in DONE
    run_tile(5, 20, 0, 1'b0, '0, '0, 1'b0, 20);

    // Empty tile
    run_tile(0, 0, 0, 1'b0, '0, '0, 1'b0, 0);
    chkv("k0_zero", O_OUT, '0);

    // Over-long K is clamped to K_MAX
    run_tile(100, 10, 0, 1'b0, '0, '0, 1'b0, 0);

    // Random tiles
    for (int t = 0; t < 6; t++) begin
      run_tile(int'($urandom_range(12, 1)), int'($urandom_range(40, 0)), 0, 1'b0, '0, '0,
               1'b1, int'($urandom_range(3, 0)));
    end

    // Abort a K=4 tile after two beats; reset coincides with a start
    @(negedge clk);
    I_START = 1'b1;
    I_K_LEN = KW'(4);
    @(negedge clk);
    I_START = 1'b0;
    I_VLD   = 1'b1;
    I_X_COL = {SA_R{16'h1234}};
    I_W_ROW = {SA_C{16'h2345}};
    @(negedge clk);
    @(negedge clk);
    I_SYNC_RST = 1'b1;
    I_START    = 1'b1;
    I_K_LEN    = KW'(1);
    @(negedge clk);
    I_SYNC_RST = 1'b0;
    I_START    = 1'b0;
    I_VLD      = 1'b0;
    chk1("abort_busy", O_BUSY, 1'b0);
    chk1("abort_rdy", O_RDY, 1'b0);
    chkv("abort_out_cleared", O_OUT, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("abort_no_vld", O_OUT_VLD, 1'b0);
    end
    run_tile(1, 0, 0, 1'b1, 16'h2000, 16'h2000, 1'b0, 0);
    chkv("after_abort_k1", O_OUT, {16{16'h2000}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
